// File: rtl/exc_commit_ctrl_pkg.sv
// Shared types and constants for the commit-side exception/ERET controller.
// Exception codes follow the MIPS32 cause.ExcCode encoding.
package exc_commit_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;

  typedef enum logic {IDLE, HOLD} state_t;

  typedef struct packed {
    logic if_adel;
    logic ri;
    logic ov;
    logic sys;
    logic bp;
    logic adel;
    logic ades;
  } exc_vec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        in_delay_slot;
    logic [4:0]  code;
    logic [31:0] badvaddr;
  } exception_t;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  im;
    logic [4:0]  rsvd_lo;
    logic        erl;
    logic        exl;
    logic        ie;
  } cp0_status_t;

  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] rsvd_hi;
    logic [7:0]  ip;
    logic        rsvd_mid;
    logic [4:0]  exc_code;
    logic [1:0]  rsvd_lo;
  } cp0_cause_t;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// Fetch redirect handshake: the controller drives the target, fetch accepts it.
interface exc_commit_ctrl_if;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;

  modport master (output redir_valid, output redir_pc, input redir_ready);
  modport slave  (input redir_valid, input redir_pc, output redir_ready);
endinterface

// File: rtl/exc_commit_ctrl_prio_enc.sv
// Resolves one commit slot's interrupt and exception flags into a single
// winning exception code and the bad virtual address that goes with it.
module exc_prio_enc
  import exc_commit_ctrl_pkg::*;
(
  input  logic        valid,
  input  logic        int_req,
  input  exc_vec_t    flags,
  input  logic [31:0] pc,
  input  logic [31:0] badvaddr_in,
  output logic        hit,
  output logic [4:0]  code,
  output logic [31:0] badvaddr
);

  always_comb begin
    hit      = valid & (int_req | (flags != '0));
    code     = CODE_INT;
    badvaddr = '0;
    if (int_req) begin
      code = CODE_INT;
    end else if (flags.if_adel) begin
      code     = CODE_ADEL;
      badvaddr = pc;
    end else if (flags.ri) begin
      code = CODE_RI;
    end else if (flags.ov) begin
      code = CODE_OV;
    end else if (flags.sys) begin
      code = CODE_SYS;
    end else if (flags.bp) begin
      code = CODE_BP;
    end else if (flags.adel) begin
      code     = CODE_ADEL;
      badvaddr = badvaddr_in;
    end else if (flags.ades) begin
      code     = CODE_ADES;
      badvaddr = badvaddr_in;
    end
  end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Commit-side exception/ERET initiator: reports to cp0, kills younger writes and
// holds a fetch redirect until accepted. Define EXC_INT_SYNC_EN for a 2-flop ext_int synchroniser.
module exc_commit_ctrl
  import exc_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          INT_LINES  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           cm_valid,
  input  logic [1:0][31:0]     cm_pc,
  input  logic [1:0]           cm_in_ds,
  input  exc_vec_t [1:0]       cm_exc,
  input  logic [1:0][31:0]     cm_badvaddr,
  input  logic [1:0]           cm_eret,
  input  logic [1:0]           cm_epc_wr,
  input  logic [1:0][31:0]     cm_epc_wd,
  input  logic [INT_LINES-1:0] ext_int,
  input  logic                 timer_interrupt,
  input  cp0_status_t          cp0_status,
  input  cp0_cause_t           cp0_cause,
  input  logic [31:0]          cp0_epc,
  output exception_t           exception,
  output logic                 is_eret,
  output logic [INT_LINES-1:0] hw_ip,
  output logic [1:0]           cm_kill,
  output logic                 flush,
  output logic                 commit_stall,
  exc_commit_ctrl_if.master    redir
);

  state_t              state, next_state;
  logic [31:0]         redir_pc_q;
  logic [INT_LINES-1:0] int_sync;
  logic [7:0]          ip_all;
  logic                int_pend;
  logic [1:0]          hit;
  logic [1:0][4:0]     code;
  logic [1:0][31:0]    bad;
  logic [1:0]          eret_v;
  logic                ev0, ev1, take, exc_win, win_slot;
  logic [31:0]         eret_target;
  logic                unused_bits;

`ifdef EXC_INT_SYNC_EN
  logic [INT_LINES-1:0] int_meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_meta <= '0;
      int_sync <= '0;
    end else begin
      int_meta <= ext_int;
      int_sync <= int_meta;
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) int_sync <= '0;
    else       int_sync <= ext_int;
  end
`endif

  // The timer comes from cp0 in our own clock domain, so it bypasses the synchroniser.
  assign hw_ip    = int_sync | {timer_interrupt, {(INT_LINES-1){1'b0}}};
  assign ip_all   = cp0_cause.ip | 8'({hw_ip, 2'b00});
  assign int_pend = cp0_status.ie & ~cp0_status.exl & ~cp0_status.erl & (|(ip_all & cp0_status.im));

  exc_prio_enc u_prio0 (
    .valid(cm_valid[0]), .int_req(int_pend), .flags(cm_exc[0]), .pc(cm_pc[0]),
    .badvaddr_in(cm_badvaddr[0]), .hit(hit[0]), .code(code[0]), .badvaddr(bad[0])
  );

  exc_prio_enc u_prio1 (
    .valid(cm_valid[1]), .int_req(int_pend & ~cm_valid[0]), .flags(cm_exc[1]), .pc(cm_pc[1]),
    .badvaddr_in(cm_badvaddr[1]), .hit(hit[1]), .code(code[1]), .badvaddr(bad[1])
  );

  assign eret_v   = cm_valid & cm_eret;
  assign ev0      = hit[0] | eret_v[0];
  assign ev1      = ~ev0 & (hit[1] | eret_v[1]);
  assign take     = (state == IDLE) & (ev0 | ev1);
  assign exc_win  = ev0 ? hit[0] : hit[1];
  assign win_slot = ~ev0;

  // An mtc0 EPC in the older slot has not reached cp0 yet, so forward it to a younger ERET.
  assign eret_target = (ev1 & ~hit[1] & cm_valid[0] & cm_epc_wr[0]) ? cm_epc_wd[0] : cp0_epc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      redir_pc_q <= '0;
    end else begin
      state <= next_state;
      if (take) redir_pc_q <= exc_win ? EXC_VECTOR : eret_target;
    end
  end

  always_comb begin
    next_state        = state;
    exception         = '0;
    is_eret           = 1'b0;
    flush             = 1'b0;
    commit_stall      = 1'b0;
    cm_kill           = 2'b00;
    redir.redir_valid = 1'b0;
    case (state)
      IDLE: begin
        if (ev0 | ev1) begin
          next_state   = HOLD;
          flush        = 1'b1;
          commit_stall = 1'b1;
          cm_kill      = (ev0 & hit[0]) ? 2'b11 : 2'b10;
          if (exc_win) begin
            exception.valid         = 1'b1;
            exception.pc            = cm_pc[win_slot];
            exception.in_delay_slot = cm_in_ds[win_slot];
            exception.code          = code[win_slot];
            exception.badvaddr      = bad[win_slot];
          end else begin
            is_eret = 1'b1;
          end
        end
      end
      HOLD: begin
        redir.redir_valid = 1'b1;
        commit_stall      = 1'b1;
        cm_kill           = 2'b11;
        if (redir.redir_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign redir.redir_pc = redir_pc_q;

  assign unused_bits = ^{cm_epc_wr[1], cm_epc_wd[1], cp0_status.rsvd_hi, cp0_status.rsvd_lo,
                         cp0_cause.bd, cp0_cause.ti, cp0_cause.rsvd_hi, cp0_cause.rsvd_mid,
                         cp0_cause.exc_code, cp0_cause.rsvd_lo};

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboard bench for exc_commit_ctrl: expected cp0 reports and redirect targets are
// queued as each commit bundle is driven and checked when the controller responds.
module tb_exc_commit_ctrl;
  import exc_commit_ctrl_pkg::*;

  localparam int          INT_LINES = 6;
  localparam logic [31:0] EXC_VEC   = 32'hBFC0_0380;
`ifdef EXC_INT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif

  typedef struct {
    logic        is_exc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        in_ds;
    logic [31:0] bad;
    logic [1:0]  kill;
    logic [31:0] redir;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           cm_valid;
  logic [1:0][31:0]     cm_pc;
  logic [1:0]           cm_in_ds;
  exc_vec_t [1:0]       cm_exc;
  logic [1:0][31:0]     cm_badvaddr;
  logic [1:0]           cm_eret;
  logic [1:0]           cm_epc_wr;
  logic [1:0][31:0]     cm_epc_wd;
  logic [INT_LINES-1:0] ext_int;
  logic                 timer_interrupt;
  cp0_status_t          cp0_status;
  cp0_cause_t           cp0_cause;
  logic [31:0]          cp0_epc;
  exception_t           exception;
  logic                 is_eret;
  logic [INT_LINES-1:0] hw_ip;
  logic [1:0]           cm_kill;
  logic                 flush;
  logic                 commit_stall;

  exc_commit_ctrl_if redir_if ();

  exc_commit_ctrl #(.EXC_VECTOR(EXC_VEC), .INT_LINES(INT_LINES)) dut (
    .clk(clk), .reset(reset), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_in_ds(cm_in_ds),
    .cm_exc(cm_exc), .cm_badvaddr(cm_badvaddr), .cm_eret(cm_eret), .cm_epc_wr(cm_epc_wr),
    .cm_epc_wd(cm_epc_wd), .ext_int(ext_int), .timer_interrupt(timer_interrupt),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .exception(exception), .is_eret(is_eret), .hw_ip(hw_ip), .cm_kill(cm_kill),
    .flush(flush), .commit_stall(commit_stall), .redir(redir_if)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t cur;
  logic [31:0] exp_redir = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exc(input logic [4:0] code, input logic [31:0] pc, input logic in_ds,
                                  input logic [31:0] badv, input logic [1:0] kill);
    exp_t e;
    e.is_exc = 1'b1; e.code = code; e.pc = pc; e.in_ds = in_ds;
    e.bad = badv; e.kill = kill; e.redir = EXC_VEC;
    return e;
  endfunction

  function automatic exp_t mk_eret(input logic [31:0] target);
    exp_t e;
    e.is_exc = 1'b0; e.code = '0; e.pc = '0; e.in_ds = 1'b0;
    e.bad = '0; e.kill = 2'b10; e.redir = target;
    return e;
  endfunction

  // Reference priority for a single slot's flags {if_adel,ri,ov,sys,bp,adel,ades}.
  function automatic logic [4:0] model_code(input logic [6:0] f);
    if (f[6]) return CODE_ADEL;
    if (f[5]) return CODE_RI;
    if (f[4]) return CODE_OV;
    if (f[3]) return CODE_SYS;
    if (f[2]) return CODE_BP;
    if (f[1]) return CODE_ADEL;
    return CODE_ADES;
  endfunction

  function automatic logic [31:0] model_bad(input logic [6:0] f, input logic [31:0] pc,
                                            input logic [31:0] dva);
    if (f[6]) return pc;
    if (f[5:2] != 4'b0) return 32'h0;
    return dva;
  endfunction

  task automatic clear_bundle();
    cm_valid = '0; cm_pc = '0; cm_in_ds = '0; cm_exc = '0; cm_badvaddr = '0;
    cm_eret = '0; cm_epc_wr = '0; cm_epc_wd = '0;
  endtask

  // Bundle is already on the inputs; runs the event cycle plus the redirect handshake.
  task automatic applyStimulus(input exp_t e, input bit expect_event, input int hold_cycles);
    int n;
    if (expect_event) sb_q.push_back(e);
    redir_if.redir_ready = 1'b1;
    if (!expect_event) begin
      @(negedge clk);
      checkOutput("pass_kill", 32'(cm_kill), 32'h0);
      checkOutput("pass_flush", 32'(flush), 32'h0);
      checkOutput("pass_stall", 32'(commit_stall), 32'h0);
    end
    @(posedge clk); #1;
    clear_bundle();
    redir_if.redir_ready = 1'b0;
    if (expect_event) begin
      n = 0;
      for (int i = 0; i < hold_cycles; i++) begin
        @(negedge clk);
        if (redir_if.redir_valid) n++;
        @(posedge clk); #1;
      end
      redir_if.redir_ready = 1'b1;
      @(negedge clk);
      if (redir_if.redir_valid) n++;
      @(posedge clk); #1;
      redir_if.redir_ready = 1'b0;
      checkOutput("hold_len", 32'(n), 32'(hold_cycles + 1));
      @(negedge clk);
      checkOutput("redir_drop", 32'(redir_if.redir_valid), 32'h0);
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (exception.valid || is_eret) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_event", 32'h1, 32'h0);
        end else begin
          cur = sb_q.pop_front();
          checkOutput("exc_valid", 32'(exception.valid), 32'(cur.is_exc));
          checkOutput("is_eret", 32'(is_eret), 32'(!cur.is_exc));
          if (cur.is_exc) begin
            checkOutput("exc_code", 32'(exception.code), 32'(cur.code));
            checkOutput("exc_pc", exception.pc, cur.pc);
            checkOutput("exc_ds", 32'(exception.in_delay_slot), 32'(cur.in_ds));
            checkOutput("exc_bad", exception.badvaddr, cur.bad);
          end
          checkOutput("ev_kill", 32'(cm_kill), 32'(cur.kill));
          checkOutput("ev_flush", 32'(flush), 32'h1);
          checkOutput("ev_stall", 32'(commit_stall), 32'h1);
          exp_redir = cur.redir;
        end
      end
      if (redir_if.redir_valid) begin
        checkOutput("redir_pc", redir_if.redir_pc, exp_redir);
        checkOutput("hold_stall", 32'(commit_stall), 32'h1);
        checkOutput("hold_kill", 32'(cm_kill), 32'h3);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  logic [6:0] prio_tab [8];

  initial begin
    logic [31:0] pc;
    prio_tab = '{7'b1100000, 7'b0011000, 7'b0001100, 7'b0000110,
                 7'b0000011, 7'b0000001, 7'b0000100, 7'b0001000};
    reset = 1'b1;
    clear_bundle();
    ext_int = '0; timer_interrupt = 1'b0;
    cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
    redir_if.redir_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_exc", 32'(exception.valid), 32'h0);
    checkOutput("rst_eret", 32'(is_eret), 32'h0);
    checkOutput("rst_flush", 32'(flush), 32'h0);
    checkOutput("rst_stall", 32'(commit_stall), 32'h0);
    checkOutput("rst_kill", 32'(cm_kill), 32'h0);
    checkOutput("rst_rvalid", 32'(redir_if.redir_valid), 32'h0);
    checkOutput("rst_rpc", redir_if.redir_pc, 32'h0);
    checkOutput("rst_hwip", 32'(hw_ip), 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // Slot 0 reserved instruction; slot 1 must be killed too.
    cm_valid = 2'b11; cm_pc[0] = 32'hBFC0_0100; cm_pc[1] = 32'hBFC0_0104; cm_exc[0].ri = 1'b1;
    applyStimulus(mk_exc(CODE_RI, 32'hBFC0_0100, 1'b0, 32'h0, 2'b11), 1'b1, 0);

    cm_valid = 2'b11; cm_pc[0] = 32'hBFC0_0200; cm_pc[1] = 32'hBFC0_0204;
    cm_in_ds[1] = 1'b1; cm_exc[1].ov = 1'b1;
    applyStimulus(mk_exc(CODE_OV, 32'hBFC0_0204, 1'b1, 32'h0, 2'b10), 1'b1, 1);

    cm_valid = 2'b11; cm_epc_wr[0] = 1'b1; cm_epc_wd[0] = 32'h8000_1000;
    cm_eret[1] = 1'b1; cp0_epc = 32'h1234_5678;
    applyStimulus(mk_eret(32'h8000_1000), 1'b1, 0);

    cm_valid = 2'b11; cm_eret = 2'b11; cp0_epc = 32'h8000_2000;
    applyStimulus(mk_eret(32'h8000_2000), 1'b1, 2);

    cm_valid = 2'b11; cm_pc[0] = 32'hBFC0_0300; cm_pc[1] = 32'hBFC0_0304;
    applyStimulus(mk_eret(32'h0), 1'b0, 0);

    // Fetch stalls the redirect for five cycles; exactly one report expected.
    cm_valid = 2'b01; cm_pc[0] = 32'hBFC0_0310; cm_exc[0].sys = 1'b1;
    applyStimulus(mk_exc(CODE_SYS, 32'hBFC0_0310, 1'b0, 32'h0, 2'b11), 1'b1, 5);

    foreach (prio_tab[i]) begin
      pc = 32'hBFC0_0600 + 32'(i * 8);
      cm_valid = 2'b01; cm_pc[0] = pc; cm_badvaddr[0] = 32'h0000_1000 + 32'(i);
      cm_exc[0] = exc_vec_t'(prio_tab[i]);
      applyStimulus(mk_exc(model_code(prio_tab[i]), pc, 1'b0,
                           model_bad(prio_tab[i], pc, 32'h0000_1000 + 32'(i)), 2'b11), 1'b1, i % 2);
    end

    cp0_status.ie = 1'b1; cp0_status.im = 8'h80; timer_interrupt = 1'b1;
    @(negedge clk);
    checkOutput("hw_ip_timer", 32'(hw_ip), 32'h20);
    @(posedge clk); #1;
    cm_valid = 2'b00;
    applyStimulus(mk_eret(32'h0), 1'b0, 0);
    cm_valid = 2'b11; cm_pc[0] = 32'hBFC0_0400; cm_pc[1] = 32'hBFC0_0404; cm_exc[0].ri = 1'b1;
    applyStimulus(mk_exc(CODE_INT, 32'hBFC0_0400, 1'b0, 32'h0, 2'b11), 1'b1, 0);
    cp0_status.exl = 1'b1;
    cm_valid = 2'b01; cm_pc[0] = 32'hBFC0_0410;
    applyStimulus(mk_eret(32'h0), 1'b0, 0);
    cm_valid = 2'b01; cm_pc[0] = 32'hBFC0_0420; cm_exc[0].bp = 1'b1;
    applyStimulus(mk_exc(CODE_BP, 32'hBFC0_0420, 1'b0, 32'h0, 2'b11), 1'b1, 0);
    cp0_status = '0; timer_interrupt = 1'b0;

    // Reset while waiting on fetch drops the redirect immediately.
    cm_valid = 2'b01; cm_pc[0] = 32'hBFC0_0500; cm_exc[0].ri = 1'b1;
    sb_q.push_back(mk_exc(CODE_RI, 32'hBFC0_0500, 1'b0, 32'h0, 2'b11));
    @(posedge clk); #1;
    clear_bundle();
    @(negedge clk);
    checkOutput("hold_entered", 32'(redir_if.redir_valid), 32'h1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_hold_rvalid", 32'(redir_if.redir_valid), 32'h0);
    checkOutput("rst_hold_exc", 32'(exception.valid), 32'h0);
    checkOutput("rst_hold_rpc", redir_if.redir_pc, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_rvalid", 32'(redir_if.redir_valid), 32'h0);
    checkOutput("post_rst_stall", 32'(commit_stall), 32'h0);
    @(posedge clk); #1;

    ext_int = 6'b000001;
    for (int i = 0; i <= SYNC_LAT; i++) begin
      @(negedge clk);
      checkOutput("hw_ip_lat", 32'(hw_ip), (i == SYNC_LAT) ? 32'h1 : 32'h0);
      if (i < SYNC_LAT) @(posedge clk);
    end
    @(posedge clk); #1 ext_int = '0;
    repeat (3) @(posedge clk);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
